// File: rtl/command_assembler_pkg.sv
// Shared types and constants for the command assembler: buffer geometry,
// ASCII codes, state and character-class enums, and buffer packing helpers.
`timescale 1ns/1ps
package cmd_pkg;

  localparam int CMD_LEN = 5;
  localparam int CNT_W   = 3;
  localparam int CMD_W   = 8 * CMD_LEN;

  typedef logic [CNT_W-1:0]          count_t;
  typedef logic [CMD_LEN-1:0][7:0]   slots_t;

  localparam count_t CMD_LEN_CNT = count_t'(CMD_LEN);

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_TILDE      = 8'h7E;
  localparam logic [7:0] ASCII_BS         = 8'h08;
  localparam logic [7:0] ASCII_DEL        = 8'h7F;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_ESC        = 8'h1B;
  localparam logic [7:0] ASCII_UC_A       = 8'h41;
  localparam logic [7:0] ASCII_UC_Z       = 8'h5A;
  localparam logic [7:0] ASCII_LC_A       = 8'h61;
  localparam logic [7:0] ASCII_LC_Z       = 8'h7A;
  localparam logic [7:0] ASCII_PLUS       = 8'h2B;
  localparam logic [7:0] ASCII_MINUS      = 8'h2D;
  localparam logic [7:0] ASCII_STAR       = 8'h2A;
  localparam logic [7:0] ASCII_SLASH      = 8'h2F;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

  localparam slots_t BLANK_SLOTS = {CMD_LEN{ASCII_SPACE}};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL,
    ST_COMMIT
  } state_e;

  typedef enum logic [2:0] {
    CC_PRINTABLE,
    CC_BACKSPACE,
    CC_ENTER,
    CC_ESCAPE,
    CC_OTHER
  } char_class_e;

  // Slot 0 holds the first typed character and lands in the most significant byte.
  function automatic logic [CMD_W-1:0] pack_slots(input slots_t slots);
    logic [CMD_W-1:0] packed_cmd;
    packed_cmd = '0;
    for (int i = 0; i < CMD_LEN; i++) begin
      packed_cmd[CMD_W-8-8*i +: 8] = slots[i];
    end
    return packed_cmd;
  endfunction

  function automatic state_e state_for_count(input count_t cnt);
    state_e st;
    if (cnt == '0) begin
      st = ST_EMPTY;
    end else if (cnt == CMD_LEN_CNT) begin
      st = ST_FULL;
    end else begin
      st = ST_FILL;
    end
    return st;
  endfunction

endpackage

// File: rtl/command_assembler_char_classifier.sv
// Combinational character classifier; with CMD_ASM_CASE_FOLD_EN defined,
// uppercase letters are folded to lowercase on the stored byte.
`timescale 1ns/1ps
module char_classifier
  import cmd_pkg::*;
(
  input  logic [7:0]  char_in,
  output char_class_e char_class,
  output logic [7:0]  char_folded
);

  always_comb begin
    // NOTE: defaulting every output before the decode keeps this block free of inferred latches.
    char_class = CC_OTHER;
    if (char_in >= ASCII_SPACE && char_in <= ASCII_TILDE) begin
      char_class = CC_PRINTABLE;
    end else if (char_in == ASCII_BS || char_in == ASCII_DEL) begin
      char_class = CC_BACKSPACE;
    end else if (char_in == ASCII_CR) begin
      char_class = CC_ENTER;
    end else if (char_in == ASCII_ESC) begin
      char_class = CC_ESCAPE;
    end
  end

`ifdef CMD_ASM_CASE_FOLD_EN
  always_comb begin
    char_folded = char_in;
    if (char_in >= ASCII_UC_A && char_in <= ASCII_UC_Z) begin
      char_folded = char_in + ASCII_CASE_DELTA;
    end
  end
`else
  assign char_folded = char_in;
`endif

endmodule

// File: rtl/command_assembler.sv
// Line-editing command assembler: buffers up to five typed characters and
// commits them on Enter. Optional case folding via CMD_ASM_CASE_FOLD_EN.
`timescale 1ns/1ps
module command_assembler
  import cmd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [CMD_W-1:0] command,
  output logic             cmd_valid,
  output logic [CNT_W-1:0] char_count,
  output logic             overflow
);

  state_e           state_q,   state_d;
  count_t           count_q,   count_d;
  slots_t           slots_q,   slots_d;
  logic [CMD_W-1:0] command_q, command_d;
  logic             overflow_q, overflow_d;

  char_class_e      char_class;
  logic [7:0]       char_folded;
  logic             accept;

  char_classifier u_classifier (
    .char_in     (char_in),
    .char_class  (char_class),
    .char_folded (char_folded)
  );

  // Held low while reset is asserted so no transfer is claimed during reset.
  assign char_ready = !reset && (state_q != ST_COMMIT);
  assign accept     = char_valid && char_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    slots_d    = slots_q;
    command_d  = command_q;
    overflow_d = overflow_q;

    if (state_q == ST_COMMIT) begin
      slots_d    = BLANK_SLOTS;
      count_d    = '0;
      overflow_d = 1'b0;
      state_d    = ST_EMPTY;
    end else if (accept) begin
      case (char_class)
        CC_PRINTABLE: begin
          if (count_q < CMD_LEN_CNT) begin
            slots_d[count_q] = char_folded;
            count_d          = count_q + count_t'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        CC_BACKSPACE: begin
          if (count_q != '0) begin
            slots_d[count_q - count_t'(1)] = ASCII_SPACE;
            count_d                        = count_q - count_t'(1);
          end
        end
        CC_ESCAPE: begin
          slots_d    = BLANK_SLOTS;
          count_d    = '0;
          overflow_d = 1'b0;
        end
        CC_ENTER: begin
          // Unused trailing slots already hold spaces, so the buffer commits as-is.
          if (count_q != '0) begin
            command_d = pack_slots(slots_q);
            state_d   = ST_COMMIT;
          end
        end
        default: begin
        end
      endcase

      if (state_d != ST_COMMIT) begin
        state_d = state_for_count(count_d);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      // NOTE: the buffer is reset deliberately: empty slots must read as spaces when committed.
      slots_q    <= BLANK_SLOTS;
      command_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
      state_q    <= state_d;
      count_q    <= count_d;
      slots_q    <= slots_d;
      command_q  <= command_d;
      overflow_q <= overflow_d;
    end
  end

  assign command    = command_q;
  assign cmd_valid  = (state_q == ST_COMMIT);
  assign char_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_command_assembler.sv
// Scoreboard bench for command_assembler: a reference model queues expected
// commands on Enter and a negedge monitor pops them on each cmd_valid pulse.
`timescale 1ns/1ps
module tb_command_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [39:0] command;
  logic        cmd_valid;
  logic [2:0]  char_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  logic [7:0]  m_buf [5];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [39:0] exp_q [$];

  command_assembler dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .command    (command),
    .cmd_valid  (cmd_valid),
    .char_count (char_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every pulse must match the oldest expected command.
  always @(negedge clk) begin
    if (!reset && cmd_valid === 1'b1) begin
      logic [39:0] e;
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: command=%h with no expected command queued", command);
      end else begin
        e = exp_q.pop_front();
        if (command !== e) begin
          errors++;
          $display("FAIL scoreboard_command: got %h expected %h", command, e);
        end
      end
    end
  end

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CMD_ASM_CASE_FOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) m_buf[i] = 8'h20;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_cnt < 5) begin
        m_buf[m_cnt] = fold(c);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (c == 8'h08 || c == 8'h7F) begin
      if (m_cnt > 0) begin
        m_cnt--;
        m_buf[m_cnt] = 8'h20;
      end
    end else if (c == 8'h1B) begin
      model_clear();
    end else if (c == 8'h0D && m_cnt > 0) begin
      exp_q.push_back({m_buf[0], m_buf[1], m_buf[2], m_buf[3], m_buf[4]});
      model_clear();
    end
  endfunction

  task automatic send_char(input logic [7:0] c);
    int waited = 0;
    while (char_ready !== 1'b1 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (char_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: char_ready=%b required 1", char_ready);
    end
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    model_char(c);
  endtask

  task automatic type_string(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    checks++;
    if (char_count !== 3'(m_cnt) || overflow !== m_ovf) begin
      errors++;
      $display("FAIL typed_state '%s': count=%0d ovf=%b required count=%0d ovf=%b",
               s, char_count, overflow, m_cnt, m_ovf);
    end
  endtask

  task automatic press_enter(input bit expect_pulse, input logic [39:0] expect_cmd);
    int p0 = pulses;
    send_char(8'h0D);
    @(negedge clk);
    checks++;
    if (cmd_valid !== expect_pulse) begin
      errors++;
      $display("FAIL enter_latency: cmd_valid=%b required %b", cmd_valid, expect_pulse);
    end
    if (expect_pulse) begin
      checks++;
      if (command !== expect_cmd || char_ready !== 1'b0) begin
        errors++;
        $display("FAIL commit_cycle: command=%h ready=%b required %h ready=0",
                 command, char_ready, expect_cmd);
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || char_count !== 3'd0 || overflow !== 1'b0 || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_commit: valid=%b count=%0d ovf=%b ready=%b required 0/0/0/1",
               cmd_valid, char_count, overflow, char_ready);
    end
    checks++;
    if (pulses - p0 !== (expect_pulse ? 1 : 0)) begin
      errors++;
      $display("FAIL pulse_count: got %0d pulses required %0d", pulses - p0, expect_pulse ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (char_ready !== 1'b0 || command !== 40'h0 || cmd_valid !== 1'b0 ||
        char_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b cmd=%h valid=%b count=%0d ovf=%b required 0/0/0/0/0",
               char_ready, command, cmd_valid, char_count, overflow);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    send_char("a");
    checks++;
    if (char_count !== 3'd1) begin
      errors++;
      $display("FAIL first_char_after_reset: count=%0d required 1", char_count);
    end
    send_char(8'h1B);
  endtask

  task automatic test_reset_word();
    type_string("reset");
    press_enter(1'b1, 40'h7265736574);
  endtask

  task automatic test_short_word();
    type_string("add");
    press_enter(1'b1, 40'h6164642020);
  endtask

  task automatic test_overflow();
    type_string("smile");
    checks++;
    if (overflow !== 1'b0 || char_count !== 3'd5) begin
      errors++;
      $display("FAIL full_no_overflow: ovf=%b count=%0d required 0/5", overflow, char_count);
    end
    type_string("x");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b required 1", overflow);
    end
    press_enter(1'b1, 40'h736D696C65);
  endtask

  task automatic test_backspace();
    send_char(8'h08);
    type_string("fx");
    send_char(8'h08);
    type_string("ight");
    press_enter(1'b1, 40'h6669676874);
    press_enter(1'b0, 40'h0);
    type_string("abc");
    send_char(8'h7F);
    send_char(8'h08);
    type_string("");
    press_enter(1'b1, 40'h6120202020);
    type_string("q");
    send_char(8'h7F);
    press_enter(1'b0, 40'h0);
  endtask

  task automatic test_escape();
    type_string("ab");
    send_char(8'h1B);
    checks++;
    if (char_count !== 3'd0 || command !== 40'h6120202020) begin
      errors++;
      $display("FAIL escape_clear: count=%0d cmd=%h required 0 and held 6120202020",
               char_count, command);
    end
    type_string("abcdef");
    send_char(8'h1B);
    type_string("ok");
    press_enter(1'b1, 40'h6F6B202020);
  endtask

  task automatic test_ignored();
    type_string("h");
    send_char(8'h00);
    send_char(8'h1F);
    send_char(8'h09);
    send_char(8'h0A);
    type_string("i");
    press_enter(1'b1, 40'h6869202020);
  endtask

  task automatic test_case_fold();
`ifdef CMD_ASM_CASE_FOLD_EN
    type_string("SMILE");
    press_enter(1'b1, 40'h736D696C65);
`else
    type_string("SMILE");
    press_enter(1'b1, 40'h534D494C45);
`endif
  endtask

  task automatic test_not_ready();
    type_string("go");
    char_in = 8'h0D;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    model_char(8'h0D);
    char_in = "z";
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_not_ready: valid=%b ready=%b required 1/0", cmd_valid, char_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (char_count !== 3'd0) begin
      errors++;
      $display("FAIL held_char_ignored: count=%0d required 0", char_count);
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    model_char("z");
    checks++;
    if (char_count !== 3'd1 || command !== 40'h676F202020) begin
      errors++;
      $display("FAIL held_char_accepted: count=%0d cmd=%h required 1 and 676F202020",
               char_count, command);
    end
    send_char(8'h1B);
  endtask

  task automatic test_back_to_back();
    type_string("+");
    press_enter(1'b1, 40'h2B20202020);
    type_string("-*/");
    press_enter(1'b1, 40'h2D2A2F2020);
    type_string("/");
    press_enter(1'b1, 40'h2F20202020);
  endtask

  task automatic test_reset_mid_fill();
    type_string("fig");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    checks++;
    if (command !== 40'h0 || char_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fill_state: cmd=%h count=%0d required 0/0", command, char_count);
    end
    press_enter(1'b0, 40'h0);
    checks++;
    if (command !== 40'h0) begin
      errors++;
      $display("FAIL reset_fill_command: cmd=%h required 0", command);
    end
  endtask

  task automatic test_reset_mid_commit();
    type_string("abc");
    send_char(8'h0D);
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || command !== 40'h0 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_commit_abort: valid=%b cmd=%h ready=%b required 0/0/0",
               cmd_valid, command, char_ready);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || command !== 40'h0 || char_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_commit_after: valid=%b cmd=%h count=%0d required 0/0/0",
               cmd_valid, command, char_count);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_reset_word();
    test_short_word();
    test_overflow();
    test_backspace();
    test_escape();
    test_ignored();
    test_case_fold();
    test_not_ready();
    test_back_to_back();
    test_reset_mid_fill();
    test_reset_mid_commit();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected commands never observed", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/command_assembler.md
COMMAND_ASSEMBLER -- requirements
Module: command_assembler

Interface
- REQ-001: clk  input  1  system clock; all state updates on rising edge.
- REQ-002: reset  input  1  asynchronous, active-high reset.
- REQ-003: char_in  input  8  ASCII character from the keyboard/UART front end.
- REQ-004: char_valid  input  1  char_in is valid this cycle.
- REQ-005: char_ready  output  1  block can accept a character; transfer occurs when char_valid && char_ready.
- REQ-006: command  output  40  committed command; first typed char in [39:32], fifth in [7:0]; feeds decoder command input.
- REQ-007: cmd_valid  output  1  one-cycle pulse marking a newly committed command.
- REQ-008: char_count  output  3  number of buffered characters, 0..5.
- REQ-009: overflow  output  1  sticky flag: a printable char was dropped because the buffer was full.

Function
- REQ-010: Printable chars (0x20..0x7E) accepted with count<5 shall be written at position count and increment count.
- REQ-011: Printable char accepted with count==5 shall be discarded and shall set overflow.
- REQ-012: Backspace (0x08 or 0x7F) shall decrement count and restore that slot to 0x20; with count==0 it is a no-op.
- REQ-013: Escape (0x1B) shall clear buffer to all 0x20, count to 0, and overflow to 0; command unchanged.
- REQ-014: Enter (0x0D) with count>0 shall transition to COMMIT; with count==0 it shall be ignored (no pulse).
- REQ-015: In COMMIT (exactly one cycle): command <= buffer, unused trailing slots 0x20; cmd_valid=1; char_ready=0.
- REQ-016: Cycle after COMMIT: buffer all 0x20, count=0, overflow=0, state EMPTY, char_ready=1.
- REQ-017: Latency: Enter accepted in cycle N -> command updated and cmd_valid high in cycle N+1.
- REQ-018: command shall hold its value between commits; edits never disturb it.
- REQ-019: All other characters (0x00..0x1F except 0x08/0x0D/0x1B) shall be accepted and ignored.
- REQ-020: States: EMPTY (count==0), FILL (1..4), FULL (5), COMMIT; transitions follow REQ-010..016.
- REQ-021: char_ready shall be 1 in EMPTY, FILL, FULL; 0 in COMMIT.
- REQ-022: char_valid while char_ready==0 shall have no effect (source must hold).

Reset
- REQ-023: reset high shall immediately force: state EMPTY, buffer all 0x20, command=40'h0, cmd_valid=0, char_count=0, overflow=0, char_ready=0 while asserted.
- REQ-024: Reset mid-COMMIT shall abort the pulse; command reads 40'h0 afterwards.
- REQ-025: First accepted character shall be possible on the first rising edge after reset deasserts.

Configuration
- REQ-026: With CMD_ASM_CASE_FOLD_EN defined, accepted uppercase 'A'..'Z' (0x41..0x5A) shall be stored as lowercase (+0x20).
- REQ-027: Without CMD_ASM_CASE_FOLD_EN, characters are stored verbatim.

Structure
- REQ-028: Shared package cmd_pkg shall hold CMD_LEN=5, ASCII constants (SPACE, BS, DEL, CR, ESC, lowercase letters, + - * /), and the state enum.
- REQ-029: Sub-module char_classifier (combinational) shall map char_in to {printable, backspace, enter, escape, other} plus case-folded byte.

Verification
- REQ-030: type "reset", Enter -> cycle after Enter: command=40'h7265736574, cmd_valid pulse 1 cycle.
- REQ-031: type "add", Enter -> command=40'h6164642020, char_count=0 next cycle.
- REQ-032: type "smilex", Enter -> overflow=1 after 'x'; command=40'h736D696C65; overflow=0 after commit.
- REQ-033: type "fx", BS, "ight", Enter -> command=40'h6669676874; Enter on empty buffer -> no cmd_valid.
- REQ-034: with CMD_ASM_CASE_FOLD_EN, type "SMILE", Enter -> command=40'h736D696C65; without it -> 40'h534D494C45.
- REQ-035: type "fig", assert reset 3 cycles, release, Enter -> no cmd_valid, command=40'h0, char_count=0.
